// File: rtl/chnl_tx_streamer.sv
// RIFFA channel transmitter: buffers accelerator result words in a small FIFO
// and returns them to the host as a single CHNL_TX transaction.
module chnl_tx_streamer #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int FIFO_DEPTH       = 4,
  parameter int BEAT_CNT_WIDTH   = 30
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [BEAT_CNT_WIDTH-1:0]   start_beats,
  input  logic [C_PCI_DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = C_PCI_DATA_WIDTH / 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  // Handshakes: a word moves on in_valid&in_ready (push) and on
  // CHNL_TX_DATA_VALID&CHNL_TX_DATA_REN (pop), both at the rising CLK edge.
  logic [1:0]                  state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0]   total_q, total_d;
  logic [BEAT_CNT_WIDTH-1:0]   sent_q, sent_d;
  logic [BEAT_CNT_WIDTH-1:0]   accepted_q, accepted_d;
  logic [31:0]                 len_q, len_d;
  logic                        done_q, done_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [C_PCI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic fifo_full;
  logic push;
  logic pop;

  assign fifo_full          = (count_q == CNT_W'(FIFO_DEPTH));
  assign busy               = (state_q != S_IDLE);
  // in_ready depends only on registered state, so a push never lands on a full FIFO.
  assign in_ready           = busy && !fifo_full && (accepted_q < total_q);
  assign CHNL_TX_DATA_VALID = (state_q == S_DATA) && (count_q != '0);
  assign push               = in_valid && in_ready;
  assign pop                = CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN;

  assign CHNL_TX_CLK  = CLK;
  assign CHNL_TX      = busy;
  assign CHNL_TX_LAST = 1'b1;
  assign CHNL_TX_OFF  = '0;
  assign CHNL_TX_LEN  = len_q;
  assign CHNL_TX_DATA = mem_q[rd_ptr_q];
  assign done         = done_q;

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    sent_d     = sent_q;
    accepted_d = accepted_q;
    len_d      = len_q;
    done_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      accepted_d = accepted_q + BEAT_CNT_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      sent_d   = sent_q + BEAT_CNT_WIDTH'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_beats != '0) begin
            total_d    = start_beats;
            len_d      = 32'(start_beats) * 32'(WORDS);
            sent_d     = '0;
            accepted_d = '0;
            state_d    = S_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (CHNL_TX_ACK) state_d = S_DATA;
      end
      S_DATA: begin
        if (pop && (sent_d == total_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      total_q    <= '0;
      sent_q     <= '0;
      accepted_q <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      sent_q     <= sent_d;
      accepted_q <= accepted_d;
      len_q      <= len_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is cleared on reset so CHNL_TX_DATA reads zero afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_chnl_tx_streamer.sv
// Directed bench for chnl_tx_streamer: scripted source/host behaviour per
// scenario, received beats compared against the generated source sequence.
module tb_chnl_tx_streamer;
  localparam int W   = 128;
  localparam int BCW = 30;
  localparam int DEPTH = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           start = 1'b0;
  logic [BCW-1:0] start_beats = '0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready, busy, done;
  logic           CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST;
  logic           CHNL_TX_ACK = 1'b0;
  logic [31:0]    CHNL_TX_LEN;
  logic [30:0]    CHNL_TX_OFF;
  logic [W-1:0]   CHNL_TX_DATA;
  logic           CHNL_TX_DATA_VALID;
  logic           CHNL_TX_DATA_REN = 1'b0;

  chnl_tx_streamer #(.C_PCI_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .BEAT_CNT_WIDTH(BCW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .start_beats(start_beats),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .CHNL_TX_CLK(CHNL_TX_CLK), .CHNL_TX(CHNL_TX),
    .CHNL_TX_ACK(CHNL_TX_ACK), .CHNL_TX_LAST(CHNL_TX_LAST),
    .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF),
    .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
    .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // driver configuration: 0 = low, 1 = high, 2 = random
  int vmode = 0;
  int rmode = 0;
  int ack_delay = 2;

  // monitor state
  int cyc, src_idx, push_cnt, done_cnt, done_cyc, tx_at_done, tx_seen;
  int first_pop_cyc, last_pop_cyc, occ, stab_viol, ovf_viol, tx_cnt;
  logic         hold_prev;
  logic [W-1:0] prev_data;
  logic [W-1:0] rcv_q[$];
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] make_word(int i);
    logic [W-1:0] w;
    for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = {8'(k + 8'hA0), 24'(i)};
    return w;
  endfunction

  task automatic clear_bench();
    src_idx = 0; push_cnt = 0; done_cnt = 0; done_cyc = -1; tx_at_done = 0;
    tx_seen = 0; first_pop_cyc = -1; last_pop_cyc = -1; occ = 0;
    stab_viol = 0; ovf_viol = 0; tx_cnt = 0; hold_prev = 1'b0;
    prev_data = '0; rcv_q.delete(); exp_q.delete();
  endtask

  // Drives one cycle of inputs, records what transfers at the coming edge,
  // then advances to 1 time unit after that edge.
  task automatic run_cycle();
    in_valid = (vmode == 2) ? 1'($urandom_range(0, 1)) : (vmode == 1);
    CHNL_TX_DATA_REN = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    CHNL_TX_ACK = CHNL_TX && (tx_cnt >= ack_delay);
    in_data = make_word(src_idx);
    #1;
    if (done) begin done_cnt++; done_cyc = cyc; tx_at_done = int'(CHNL_TX); end
    if (CHNL_TX) tx_seen = 1;
    if (in_ready && occ >= DEPTH) ovf_viol++;
    if (hold_prev && (!CHNL_TX_DATA_VALID || CHNL_TX_DATA !== prev_data)) stab_viol++;
    hold_prev = CHNL_TX_DATA_VALID && !CHNL_TX_DATA_REN;
    prev_data = CHNL_TX_DATA;
    if (in_valid && in_ready) begin push_cnt++; src_idx++; occ++; end
    if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
      rcv_q.push_back(CHNL_TX_DATA);
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      occ--;
    end
    tx_cnt = CHNL_TX ? tx_cnt + 1 : 0;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_start(int beats);
    start = 1'b1;
    start_beats = BCW'(beats);
    run_cycle();
    start = 1'b0;
    start_beats = '0;
  endtask

  task automatic run_to_done(int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) run_cycle();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    checks++; if (CHNL_TX !== 1'b0) begin errors++; $display("FAIL reset_tx got %0b exp 0", CHNL_TX); end
    checks++; if (CHNL_TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", CHNL_TX_DATA_VALID); end
    checks++; if (CHNL_TX_LEN !== 32'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", CHNL_TX_LEN); end
    checks++; if (CHNL_TX_DATA !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", CHNL_TX_DATA); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got rdy=%0b busy=%0b done=%0b exp 0 0 0", in_ready, busy, done);
    end
    checks++; if (CHNL_TX_LAST !== 1'b1 || CHNL_TX_OFF !== 31'd0) begin
      errors++; $display("FAIL reset_const got last=%0b off=%0d exp 1 0", CHNL_TX_LAST, CHNL_TX_OFF);
    end
  endtask

  task automatic test_basic();
    int bad;
    clear_bench();
    vmode = 1; rmode = 1; ack_delay = 2;
    do_start(1024);
    checks++; if (CHNL_TX_LEN !== 32'd4096) begin errors++; $display("FAIL basic_len got %0d exp 4096", CHNL_TX_LEN); end
    checks++; if (CHNL_TX !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_req got tx=%0b busy=%0b exp 1 1", CHNL_TX, busy); end
    run_to_done(3000);
    repeat (3) run_cycle();
    for (int i = 0; i < 1024; i++) exp_q.push_back(make_word(i));
    bad = -1;
    for (int i = 0; i < rcv_q.size() && i < 1024; i++) if (bad < 0 && rcv_q[i] !== exp_q[i]) bad = i;
    checks++; if (rcv_q.size() != 1024) begin errors++; $display("FAIL basic_count got %0d exp 1024", rcv_q.size()); end
    checks++; if (bad >= 0) begin errors++; $display("FAIL basic_order at beat %0d got %h exp %h", bad, rcv_q[bad], exp_q[bad]); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (done_cyc != last_pop_cyc + 1) begin errors++; $display("FAIL basic_done_cyc got %0d exp %0d", done_cyc, last_pop_cyc + 1); end
    checks++; if (tx_at_done != 0) begin errors++; $display("FAIL basic_tx_at_done got %0d exp 0", tx_at_done); end
    checks++; if (last_pop_cyc - first_pop_cyc != 1023) begin errors++; $display("FAIL basic_rate got %0d exp 1023", last_pop_cyc - first_pop_cyc); end
    vmode = 0; rmode = 0;
  endtask

  task automatic test_random_stalls();
    int bad;
    clear_bench();
    void'($urandom(20));
    vmode = 2; rmode = 2; ack_delay = 2;
    do_start(256);
    run_to_done(6000);
    repeat (3) run_cycle();
    for (int i = 0; i < 256; i++) exp_q.push_back(make_word(i));
    bad = -1;
    for (int i = 0; i < rcv_q.size() && i < 256; i++) if (bad < 0 && rcv_q[i] !== exp_q[i]) bad = i;
    checks++; if (rcv_q.size() != 256) begin errors++; $display("FAIL rand_count got %0d exp 256", rcv_q.size()); end
    checks++; if (bad >= 0) begin errors++; $display("FAIL rand_order at beat %0d got %h exp %h", bad, rcv_q[bad], exp_q[bad]); end
    checks++; if (push_cnt != 256) begin errors++; $display("FAIL rand_push got %0d exp 256", push_cnt); end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_stable got %0d exp 0", stab_viol); end
    checks++; if (ovf_viol != 0) begin errors++; $display("FAIL rand_full_ready got %0d exp 0", ovf_viol); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand_done_cnt got %0d exp 1", done_cnt); end
    vmode = 0; rmode = 0;
  endtask

  task automatic test_late_ack();
    int bad;
    clear_bench();
    vmode = 1; rmode = 1; ack_delay = 20;
    do_start(8);
    repeat (14) run_cycle();
    checks++; if (occ != 4) begin errors++; $display("FAIL late_occ got %0d exp 4", occ); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL late_ready got %0b exp 0", in_ready); end
    checks++; if (CHNL_TX_DATA_VALID !== 1'b0 || rcv_q.size() != 0) begin
      errors++; $display("FAIL late_valid got valid=%0b beats=%0d exp 0 0", CHNL_TX_DATA_VALID, rcv_q.size());
    end
    run_to_done(200);
    repeat (2) run_cycle();
    for (int i = 0; i < 8; i++) exp_q.push_back(make_word(i));
    bad = -1;
    for (int i = 0; i < rcv_q.size() && i < 8; i++) if (bad < 0 && rcv_q[i] !== exp_q[i]) bad = i;
    checks++; if (rcv_q.size() != 8 || bad >= 0) begin errors++; $display("FAIL late_beats got %0d first_bad=%0d exp 8 -1", rcv_q.size(), bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL late_done_cnt got %0d exp 1", done_cnt); end
    vmode = 0; rmode = 0;
  endtask

  task automatic test_zero_and_busy();
    clear_bench();
    vmode = 0; rmode = 0; ack_delay = 2;
    do_start(0);
    checks++; if (done !== 1'b1 || CHNL_TX !== 1'b0) begin errors++; $display("FAIL zero_done got done=%0b tx=%0b exp 1 0", done, CHNL_TX); end
    repeat (3) run_cycle();
    checks++; if (done_cnt != 1 || tx_seen != 0) begin errors++; $display("FAIL zero_quiet got done_cnt=%0d tx_seen=%0d exp 1 0", done_cnt, tx_seen); end
    clear_bench();
    vmode = 1; rmode = 1;
    do_start(4);
    repeat (2) run_cycle();
    do_start(9);
    checks++; if (CHNL_TX_LEN !== 32'd16) begin errors++; $display("FAIL busy_len got %0d exp 16", CHNL_TX_LEN); end
    run_to_done(100);
    checks++; if (rcv_q.size() != 4 || push_cnt != 4) begin errors++; $display("FAIL busy_beats got %0d push %0d exp 4 4", rcv_q.size(), push_cnt); end
    tx_seen = 0;
    repeat (4) run_cycle();
    checks++; if (tx_seen != 0 || done_cnt != 1) begin errors++; $display("FAIL busy_ignored got tx_seen=%0d done_cnt=%0d exp 0 1", tx_seen, done_cnt); end
    vmode = 0; rmode = 0;
  endtask

  task automatic test_overrun();
    clear_bench();
    vmode = 1; rmode = 0; ack_delay = 2;
    do_start(3);
    repeat (9) run_cycle();
    checks++; if (push_cnt != 3) begin errors++; $display("FAIL overrun_push got %0d exp 3", push_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL overrun_ready got %0b exp 0", in_ready); end
    vmode = 0; rmode = 1;
    run_to_done(50);
    checks++; if (rcv_q.size() != 3 || done_cnt != 1) begin errors++; $display("FAIL overrun_done got beats=%0d done=%0d exp 3 1", rcv_q.size(), done_cnt); end
    rmode = 0;
  endtask

  task automatic test_reset_mid();
    clear_bench();
    vmode = 1; rmode = 1; ack_delay = 2;
    do_start(16);
    for (int i = 0; i < 100 && rcv_q.size() < 5; i++) run_cycle();
    checks++; if (rcv_q.size() != 5) begin errors++; $display("FAIL rstmid_progress got %0d exp 5", rcv_q.size()); end
    RST = 1'b1;
    run_cycle();
    RST = 1'b0;
    checks++; if (CHNL_TX !== 1'b0 || CHNL_TX_DATA_VALID !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got tx=%0b valid=%0b busy=%0b done=%0b exp 0 0 0 0", CHNL_TX, CHNL_TX_DATA_VALID, busy, done);
    end
    clear_bench();
    vmode = 0; rmode = 0;
    repeat (3) run_cycle();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", done_cnt); end
    clear_bench();
    vmode = 1; rmode = 1;
    do_start(2);
    checks++; if (CHNL_TX_LEN !== 32'd8) begin errors++; $display("FAIL rstmid_len got %0d exp 8", CHNL_TX_LEN); end
    run_to_done(50);
    exp_q.push_back(make_word(0));
    exp_q.push_back(make_word(1));
    checks++; if (rcv_q.size() != 2 || done_cnt != 1) begin errors++; $display("FAIL rstmid_restart got beats=%0d done=%0d exp 2 1", rcv_q.size(), done_cnt); end
    else if (rcv_q[0] !== exp_q[0] || rcv_q[1] !== exp_q[1]) begin errors++; $display("FAIL rstmid_data got %h exp %h", rcv_q[0], exp_q[0]); end
    vmode = 0; rmode = 0;
  endtask

  initial begin
    cyc = 0;
    clear_bench();
    test_reset();
    test_basic();
    test_random_stalls();
    test_late_ack();
    test_zero_and_busy();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
